input_conditioner: RTL and testbench

Front-end stage for the player buttons: synchronizes the four raw asynchronous push-button lines, debounces each one, and presents clean levels (`left`, `right`, `up`, `down`) plus an encoded 16-bit movement word to the CPU datapath's game-controller input. It also raises a one-cycle press pulse on each new press and latches the most recent press into a sticky word with a pending/ack handshake, so software polling through the register bank cannot miss a tap. It sits directly upstream of the datapath top, between the board pins and its `left/right/up/down` inputs.

---
 rtl/input_conditioner.sv | 122 ++++++++++++
 tb/tb_input_conditioner.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/input_conditioner.sv
// Button front end: two-flop synchronizer, per-button debounce, priority encoding,
// and a sticky last-press word with a pending/ack handshake for polling software.
module input_conditioner #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W           = 19
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_left,
  input  logic        btn_right,
  input  logic        btn_up,
  input  logic        btn_down,
  input  logic        move_ack,
  output logic        left,
  output logic        right,
  output logic        up,
  output logic        down,
  output logic [15:0] movement,
  output logic        press_pulse,
  output logic [15:0] last_move,
  output logic        move_pending
);

  localparam int                 NBTN     = 4;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  localparam logic [15:0] CODE_NONE  = 16'd0;
  localparam logic [15:0] CODE_UP    = 16'd1;
  localparam logic [15:0] CODE_DOWN  = 16'd2;
  localparam logic [15:0] CODE_LEFT  = 16'd3;
  localparam logic [15:0] CODE_RIGHT = 16'd4;

  // Bit order everywhere: [0]=up, [1]=down, [2]=left, [3]=right (priority order).
  logic [NBTN-1:0]  raw;
  logic [NBTN-1:0]  s1;
  logic [NBTN-1:0]  s2;
  logic [NBTN-1:0]  stable;
  logic [NBTN-1:0]  stable_p1;
  logic [NBTN-1:0]  rise;
  logic [CNT_W-1:0] cnt [NBTN];

  logic [15:0] movement_q;
  logic        press_pulse_q;
  logic [15:0] last_move_q;
  logic        move_pending_q;

  function automatic logic [15:0] encode_dir(input logic [NBTN-1:0] b);
    logic [15:0] code;
    code = CODE_NONE;
    if (b[0])      code = CODE_UP;
    else if (b[1]) code = CODE_DOWN;
    else if (b[2]) code = CODE_LEFT;
    else if (b[3]) code = CODE_RIGHT;
    return code;
  endfunction

  assign raw = {btn_right, btn_left, btn_down, btn_up};

  // Stage: two-flop synchronizer for the asynchronous pins.
  always_ff @(posedge clk) begin
    if (!reset) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Stage: debounce -- stable flips only after DEBOUNCE_CYCLES consecutive disagreements.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stable <= '0;
      for (int i = 0; i < NBTN; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NBTN; i++) begin
        if (s2[i] == stable[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          stable[i] <= s2[i];
          cnt[i]    <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign rise = stable & ~stable_p1;

  // Stage: edge history, held-state encoding and press/handshake bookkeeping.
  always_ff @(posedge clk) begin
    if (!reset) begin
      stable_p1      <= '0;
      movement_q     <= '0;
      press_pulse_q  <= 1'b0;
      last_move_q    <= '0;
      move_pending_q <= 1'b0;
    end else begin
      stable_p1     <= stable;
      movement_q    <= encode_dir(stable);
      press_pulse_q <= |rise;
      if (|rise) begin
        // A press beats a same-cycle ack so the new code is never lost.
        last_move_q    <= encode_dir(rise);
        move_pending_q <= 1'b1;
      end else if (move_ack) begin
        move_pending_q <= 1'b0;
      end
    end
  end

  assign up           = stable[0];
  assign down         = stable[1];
  assign left         = stable[2];
  assign right        = stable[3];
  assign movement     = movement_q;
  assign press_pulse  = press_pulse_q;
  assign last_move    = last_move_q;
  assign move_pending = move_pending_q;

endmodule

// File: tb/tb_input_conditioner.sv
// Directed bench for input_conditioner with DEBOUNCE_CYCLES = 4.
module tb_input_conditioner;

  logic        clk;
  logic        reset;
  logic        btn_left, btn_right, btn_up, btn_down;
  logic        move_ack;
  logic        left, right, up, down;
  logic [15:0] movement;
  logic        press_pulse;
  logic [15:0] last_move;
  logic        move_pending;

  int checks;
  int errors;
  int pulses;

  input_conditioner #(
    .DEBOUNCE_CYCLES(4),
    .CNT_W          (3)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .btn_left    (btn_left),
    .btn_right   (btn_right),
    .btn_up      (btn_up),
    .btn_down    (btn_down),
    .move_ack    (move_ack),
    .left        (left),
    .right       (right),
    .up          (up),
    .down        (down),
    .movement    (movement),
    .press_pulse (press_pulse),
    .last_move   (last_move),
    .move_pending(move_pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_lvl"}, {12'd0, left, right, up, down}, 16'd0);
    check({tag, "_mov"}, movement, 16'd0);
    check({tag, "_pulse"}, {15'd0, press_pulse}, 16'd0);
    check({tag, "_last"}, last_move, 16'd0);
    check({tag, "_pend"}, {15'd0, move_pending}, 16'd0);
  endtask

  task automatic release_all_and_settle();
    btn_left = 0; btn_right = 0; btn_up = 0; btn_down = 0; move_ack = 0;
    tick(10);
    move_ack = 1;
    tick(1);
    move_ack = 0;
    tick(1);
  endtask

  initial begin
    checks = 0; errors = 0;
    reset = 0; move_ack = 0;
    btn_left = 0; btn_right = 0; btn_down = 0; btn_up = 1;

    // 1: reset held with btn_up high, then release
    tick(3);
    check_all_zero("t1_rst");
    reset = 1;
    tick(5);
    check("t1_up_e5", {15'd0, up}, 16'd0);
    tick(1);
    check("t1_up_e6", {15'd0, up}, 16'd1);
    check("t1_mov_e6", movement, 16'd0);
    check("t1_pulse_e6", {15'd0, press_pulse}, 16'd0);
    tick(1);
    check("t1_mov_e7", movement, 16'd1);
    check("t1_pulse_e7", {15'd0, press_pulse}, 16'd1);
    check("t1_last_e7", last_move, 16'd1);
    check("t1_pend_e7", {15'd0, move_pending}, 16'd1);
    tick(1);
    check("t1_pulse_e8", {15'd0, press_pulse}, 16'd0);
    check("t1_pend_e8", {15'd0, move_pending}, 16'd1);
    release_all_and_settle();
    check("t1_mov_rel", movement, 16'd0);
    check("t1_pend_ack", {15'd0, move_pending}, 16'd0);
    check("t1_last_hold", last_move, 16'd1);

    // 2: 3-cycle glitch on btn_left is rejected
    btn_left = 1;
    pulses = 0;
    for (int k = 0; k < 3; k++) begin
      tick(1);
      check("t2_left", {15'd0, left}, 16'd0);
      pulses += int'(press_pulse);
    end
    btn_left = 0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("t2_left", {15'd0, left}, 16'd0);
      check("t2_mov", movement, 16'd0);
      pulses += int'(press_pulse);
    end
    check("t2_pulses", 16'(pulses), 16'd0);

    // 3: right held, one pulse, then ack
    btn_right = 1;
    tick(6);
    check("t3_right", {15'd0, right}, 16'd1);
    tick(1);
    check("t3_mov", movement, 16'd4);
    check("t3_last", last_move, 16'd4);
    check("t3_pulse", {15'd0, press_pulse}, 16'd1);
    check("t3_pend", {15'd0, move_pending}, 16'd1);
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick(1);
      pulses += int'(press_pulse);
    end
    check("t3_extra_pulses", 16'(pulses), 16'd0);
    move_ack = 1;
    tick(1);
    move_ack = 0;
    check("t3_pend_ack", {15'd0, move_pending}, 16'd0);
    check("t3_last_hold", last_move, 16'd4);
    tick(2);
    check("t3_ack_idle", {15'd0, move_pending}, 16'd0);
    release_all_and_settle();

    // 4: down and left rise together -> one pulse, down wins
    btn_down = 1; btn_left = 1;
    pulses = 0;
    for (int k = 0; k < 12; k++) begin
      tick(1);
      pulses += int'(press_pulse);
      if (k == 6) begin
        check("t4_pulse_e7", {15'd0, press_pulse}, 16'd1);
        check("t4_last", last_move, 16'd2);
        check("t4_mov", movement, 16'd2);
      end
    end
    check("t4_pulses", 16'(pulses), 16'd1);
    release_all_and_settle();

    // 5: up held, left press collides with ack
    btn_up = 1;
    tick(10);
    check("t5_mov_up", movement, 16'd1);
    move_ack = 1;
    tick(1);
    move_ack = 0;
    check("t5_pend_clr", {15'd0, move_pending}, 16'd0);
    btn_left = 1;
    tick(6);
    move_ack = 1;
    tick(1);
    move_ack = 0;
    check("t5_pulse", {15'd0, press_pulse}, 16'd1);
    check("t5_last", last_move, 16'd3);
    check("t5_pend", {15'd0, move_pending}, 16'd1);
    check("t5_mov", movement, 16'd1);
    tick(1);
    check("t5_pend_after", {15'd0, move_pending}, 16'd1);
    release_all_and_settle();

    // 6: reset mid-hold discards state, press reappears
    btn_down = 1;
    tick(20);
    check("t6_down_hold", {15'd0, down}, 16'd1);
    check("t6_mov_hold", movement, 16'd2);
    reset = 0;
    tick(1);
    reset = 1;
    check_all_zero("t6_rst");
    tick(5);
    check("t6_down_e5", {15'd0, down}, 16'd0);
    tick(1);
    check("t6_down_e6", {15'd0, down}, 16'd1);
    check("t6_mov_e6", movement, 16'd0);
    tick(1);
    check("t6_mov_e7", movement, 16'd2);
    check("t6_pulse_e7", {15'd0, press_pulse}, 16'd1);
    check("t6_last_e7", last_move, 16'd2);
    check("t6_pend_e7", {15'd0, move_pending}, 16'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
